// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_t;

    localparam int RF_WIDTH      = 32;
    localparam int RF_DEPTH_BITS = 5;
    localparam int RF_CNT_WIDTH  = 16;

endpackage

// File: rtl/rf_arb_grant.sv
// Two-requester grant with LastGrant history; combinational grant, zero latency.
// Conflict policy: A always wins, or alternation when RF_ARB_ROUND_ROBIN_EN is defined.
module rf_arb_grant
    import rf_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   a_valid,
    input  logic   b_valid,
    output grant_t grant
);

    grant_t last_grant;

    always_comb begin
        grant = GNT_NONE;
        if (a_valid && b_valid) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            grant = (last_grant == GNT_A) ? GNT_B : GNT_A;
`else
            grant = GNT_A;
`endif
        end else if (a_valid) begin
            grant = GNT_A;
        end else if (b_valid) begin
            grant = GNT_B;
        end
    end

`ifndef RF_ARB_ROUND_ROBIN_EN
    // History is kept for observability even though fixed priority ignores it.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == GNT_A);
`endif

    // A grant is always an accepted handshake, since Ready is the grant itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_B;
        end else if (grant != GNT_NONE) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one register-file write port; 1-cycle latency.
// Losing source is held off via Ready; conflict policy set by RF_ARB_ROUND_ROBIN_EN.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int WIDTH      = RF_WIDTH,
    parameter int DEPTH_BITS = RF_DEPTH_BITS,
    parameter int CNT_WIDTH  = RF_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  AValid,
    input  logic [DEPTH_BITS-1:0] AAddress,
    input  logic [WIDTH-1:0]      AData,
    output logic                  AReady,
    input  logic                  BValid,
    input  logic [DEPTH_BITS-1:0] BAddress,
    input  logic [WIDTH-1:0]      BData,
    output logic                  BReady,
    output logic                  WrEn,
    output logic [DEPTH_BITS-1:0] WrAddress,
    output logic [WIDTH-1:0]      WrData,
    output logic [CNT_WIDTH-1:0]  ConflictCount
);

    grant_t grant;

    rf_arb_grant u_grant (
        .clk     (CLK),
        .rst_n   (RST),
        .a_valid (AValid),
        .b_valid (BValid),
        .grant   (grant)
    );

    assign AReady = (grant == GNT_A);
    assign BReady = (grant == GNT_B);

    // x0 writes complete the handshake but never raise WrEn.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            WrEn      <= 1'b0;
            WrAddress <= '0;
            WrData    <= '0;
        end else begin
            case (grant)
                GNT_A: begin
                    WrEn      <= (AAddress != '0);
                    WrAddress <= AAddress;
                    WrData    <= AData;
                end
                GNT_B: begin
                    WrEn      <= (BAddress != '0);
                    WrAddress <= BAddress;
                    WrData    <= BData;
                end
                default: begin
                    WrEn      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ConflictCount <= '0;
        end else if (AValid && BValid && (ConflictCount != {CNT_WIDTH{1'b1}})) begin
            ConflictCount <= ConflictCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; expectations follow RF_ARB_ROUND_ROBIN_EN.
module tb_rf_write_arbiter;

    localparam int WIDTH      = 32;
    localparam int DEPTH_BITS = 5;
    localparam int CNT_WIDTH  = 4;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  AValid, BValid;
    logic [DEPTH_BITS-1:0] AAddress, BAddress;
    logic [WIDTH-1:0]      AData, BData;
    logic                  AReady, BReady;
    logic                  WrEn;
    logic [DEPTH_BITS-1:0] WrAddress;
    logic [WIDTH-1:0]      WrData;
    logic [CNT_WIDTH-1:0]  ConflictCount;

    int n_cmp = 0;
    int n_bad = 0;

    rf_write_arbiter #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (DEPTH_BITS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .AValid        (AValid),
        .AAddress      (AAddress),
        .AData         (AData),
        .AReady        (AReady),
        .BValid        (BValid),
        .BAddress      (BAddress),
        .BData         (BData),
        .BReady        (BReady),
        .WrEn          (WrEn),
        .WrAddress     (WrAddress),
        .WrData        (WrData),
        .ConflictCount (ConflictCount)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        AValid = 1'b0;
        BValid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        AValid = 1'b1; BValid = 1'b1;
        AAddress = 5'd3; BAddress = 5'd4;
        AData = 32'h1111_1111; BData = 32'h2222_2222;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++; if (WrEn !== 1'b0) begin n_bad++; $display("FAIL reset_wren: got %0h expected 0", WrEn); end
        n_cmp++; if (WrAddress !== 5'd0) begin n_bad++; $display("FAIL reset_wraddr: got %0h expected 0", WrAddress); end
        n_cmp++; if (WrData !== 32'd0) begin n_bad++; $display("FAIL reset_wrdata: got %0h expected 0", WrData); end
        n_cmp++; if (ConflictCount !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0h expected 0", ConflictCount); end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        n_cmp++; if (AReady !== 1'b1) begin n_bad++; $display("FAIL first_conflict_aready: got %0h expected 1", AReady); end
        n_cmp++; if (BReady !== 1'b0) begin n_bad++; $display("FAIL first_conflict_bready: got %0h expected 0", BReady); end
        AValid = 1'b0; BValid = 1'b0;
    endtask

    task automatic test_single_a();
        do_reset();
        @(negedge CLK);
        AValid = 1'b1; AAddress = 5'd5; AData = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (AReady !== 1'b1) begin n_bad++; $display("FAIL single_a_aready: got %0h expected 1", AReady); end
        n_cmp++; if (BReady !== 1'b0) begin n_bad++; $display("FAIL single_a_bready: got %0h expected 0", BReady); end
        @(posedge CLK); #1;
        AValid = 1'b0;
        n_cmp++; if (WrEn !== 1'b1) begin n_bad++; $display("FAIL single_a_wren: got %0h expected 1", WrEn); end
        n_cmp++; if (WrAddress !== 5'd5) begin n_bad++; $display("FAIL single_a_wraddr: got %0h expected 5", WrAddress); end
        n_cmp++; if (WrData !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_a_wrdata: got %0h expected deadbeef", WrData); end
        @(posedge CLK); #1;
        n_cmp++; if (WrEn !== 1'b0) begin n_bad++; $display("FAIL idle_wren: got %0h expected 0", WrEn); end
        n_cmp++; if (WrAddress !== 5'd5) begin n_bad++; $display("FAIL idle_wraddr_hold: got %0h expected 5", WrAddress); end
        n_cmp++; if (WrData !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL idle_wrdata_hold: got %0h expected deadbeef", WrData); end
        n_cmp++; if (ConflictCount !== 4'd0) begin n_bad++; $display("FAIL single_a_count: got %0h expected 0", ConflictCount); end
    endtask

    task automatic test_conflict();
        logic exp_a [4];
`ifdef RF_ARB_ROUND_ROBIN_EN
        exp_a[0] = 1'b1; exp_a[1] = 1'b0; exp_a[2] = 1'b1; exp_a[3] = 1'b0;
`else
        exp_a[0] = 1'b1; exp_a[1] = 1'b1; exp_a[2] = 1'b1; exp_a[3] = 1'b1;
`endif
        do_reset();
        @(negedge CLK);
        AValid = 1'b1; AAddress = 5'd10; AData = 32'hAAAA_0001;
        BValid = 1'b1; BAddress = 5'd20; BData = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (AReady !== exp_a[i]) begin n_bad++; $display("FAIL conflict_aready[%0d]: got %0h expected %0h", i, AReady, exp_a[i]); end
            n_cmp++; if (BReady !== !exp_a[i]) begin n_bad++; $display("FAIL conflict_bready[%0d]: got %0h expected %0h", i, BReady, !exp_a[i]); end
            @(posedge CLK); #1;
            n_cmp++; if (WrAddress !== (exp_a[i] ? 5'd10 : 5'd20)) begin n_bad++; $display("FAIL conflict_wraddr[%0d]: got %0h expected %0h", i, WrAddress, exp_a[i] ? 5'd10 : 5'd20); end
            @(negedge CLK);
        end
        AValid = 1'b0; BValid = 1'b0;
        #1;
        n_cmp++; if (ConflictCount !== 4'd4) begin n_bad++; $display("FAIL conflict_count: got %0h expected 4", ConflictCount); end
    endtask

    task automatic test_x0();
        do_reset();
        @(negedge CLK);
        BValid = 1'b1; BAddress = 5'd0; BData = 32'h0000_1234;
        #1;
        n_cmp++; if (BReady !== 1'b1) begin n_bad++; $display("FAIL x0_bready: got %0h expected 1", BReady); end
        n_cmp++; if (AReady !== 1'b0) begin n_bad++; $display("FAIL x0_aready: got %0h expected 0", AReady); end
        @(posedge CLK); #1;
        BValid = 1'b0;
        n_cmp++; if (WrEn !== 1'b0) begin n_bad++; $display("FAIL x0_wren: got %0h expected 0", WrEn); end
        n_cmp++; if (WrData !== 32'h0000_1234) begin n_bad++; $display("FAIL x0_wrdata: got %0h expected 1234", WrData); end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge CLK);
        AValid = 1'b1; AAddress = 5'd1; AData = 32'h1;
        BValid = 1'b1; BAddress = 5'd2; BData = 32'h2;
        repeat (10) @(posedge CLK);
        #1;
        n_cmp++; if (ConflictCount !== 4'd10) begin n_bad++; $display("FAIL sat_count_mid: got %0h expected a", ConflictCount); end
        repeat (9) @(posedge CLK);
        #1;
        n_cmp++; if (ConflictCount !== 4'hF) begin n_bad++; $display("FAIL sat_count_final: got %0h expected f", ConflictCount); end
        AValid = 1'b0; BValid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge CLK);
        AValid = 1'b1; AAddress = 5'd7; AData = 32'h0000_0077;
        @(posedge CLK); #1;
        AValid = 1'b0;
        n_cmp++; if (WrEn !== 1'b1) begin n_bad++; $display("FAIL mid_accept_wren: got %0h expected 1", WrEn); end
        #2;
        RST = 1'b0;
        #1;
        n_cmp++; if (WrEn !== 1'b0) begin n_bad++; $display("FAIL mid_reset_wren: got %0h expected 0", WrEn); end
        n_cmp++; if (WrAddress !== 5'd0) begin n_bad++; $display("FAIL mid_reset_wraddr: got %0h expected 0", WrAddress); end
        n_cmp++; if (WrData !== 32'd0) begin n_bad++; $display("FAIL mid_reset_wrdata: got %0h expected 0", WrData); end
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if (WrEn !== 1'b0) begin n_bad++; $display("FAIL post_reset_wren: got %0h expected 0", WrEn); end
    endtask

    initial begin
        RST = 1'b1;
        AValid = 1'b0; BValid = 1'b0;
        AAddress = '0; BAddress = '0;
        AData = '0; BData = '0;
        test_reset();
        test_single_a();
        test_conflict();
        test_x0();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
